// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle IEEE-754 single-precision add/subtract sequencer
// Ports: clk, rst (sync, active-high); in_valid/in_ready with a, b, op (0 add, 1 sub)
//        form the operand handshake; out_valid/out_ready with result, ovf, unf form
//        the result handshake; busy is high whenever the FSM is not IDLE.
// ALIGN_ITER=1 aligns the smaller mantissa one bit per ALIGN cycle.
// Define FP_ADDSUB_SPECIALS_EN to route inf/NaN operands through a SPECIAL state.
module fp_addsub_seq #(
  parameter int ALIGN_ITER = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        ovf,
  output logic        unf,
  output logic        busy
);
  typedef enum logic [2:0] {
    IDLE, ALIGN, ADD, NORM, DONE
`ifdef FP_ADDSUB_SPECIALS_EN
    , SPECIAL
`endif
  } state_t;
  state_t      r_state;
  logic [23:0] r_big_m, r_small_m;
  logic [7:0]  r_exp;
  logic        r_sign, r_sign_s;
  logic [4:0]  r_cnt;
  logic [24:0] r_sum;
  logic [31:0] r_result;
  logic        r_ovf, r_unf, r_out_valid;
  logic        w_sb, w_a_big;
  logic [7:0]  w_diff;
  logic [23:0] w_ma, w_mb;
  logic [4:0]  w_cnt;
  assign w_sb    = b[31] ^ op;
  // raw magnitude compare orders by exponent first, then fraction; ties favour A
  assign w_a_big = a[30:0] >= b[30:0];
  assign w_ma    = a[30:23] == 8'd0 ? 24'd0 : {1'b1, a[22:0]};
  assign w_mb    = b[30:23] == 8'd0 ? 24'd0 : {1'b1, b[22:0]};
  assign w_diff  = w_a_big ? a[30:23] - b[30:23] : b[30:23] - a[30:23];
  // shifts of 24 or more clear the 24-bit mantissa, so the count saturates there
  assign w_cnt   = w_diff >= 8'd24 ? 5'd24 : w_diff[4:0];
`ifdef FP_ADDSUB_SPECIALS_EN
  logic        w_a_max, w_b_max, w_special;
  logic [31:0] w_spec, r_spec;
  assign w_a_max   = &a[30:23];
  assign w_b_max   = &b[30:23];
  assign w_special = w_a_max | w_b_max;
  assign w_spec    = ((w_a_max & |a[22:0]) | (w_b_max & |b[22:0]) | (w_a_max & w_b_max & (a[31] != w_sb)))
                   ? 32'h7FC00000 : {w_a_max ? a[31] : w_sb, 8'hFF, 23'd0};
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_result    <= 32'd0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_big_m   <= w_a_big ? w_ma : w_mb;
          r_small_m <= w_a_big ? w_mb : w_ma;
          r_exp     <= w_a_big ? a[30:23] : b[30:23];
          r_sign    <= w_a_big ? a[31] : w_sb;
          r_sign_s  <= w_a_big ? w_sb : a[31];
          r_cnt     <= w_cnt;
`ifdef FP_ADDSUB_SPECIALS_EN
          r_spec    <= w_spec;
          r_state   <= w_special ? SPECIAL : ALIGN;
`else
          r_state   <= ALIGN;
`endif
        end
        ALIGN: if (ALIGN_ITER != 0) begin
          r_small_m <= r_small_m >> (r_cnt != 5'd0);
          r_cnt     <= r_cnt - {4'd0, r_cnt != 5'd0};
          r_state   <= r_cnt <= 5'd1 ? ADD : ALIGN;
        end else begin
          r_small_m <= r_small_m >> r_cnt;
          r_state   <= ADD;
        end
        ADD: begin
          r_sum   <= r_sign == r_sign_s ? {1'b0, r_big_m} + {1'b0, r_small_m}
                                        : {1'b0, r_big_m} - {1'b0, r_small_m};
          r_state <= NORM;
        end
        NORM: if (r_sum[24]) begin
          r_result    <= r_exp >= 8'd254 ? {r_sign, 8'hFF, 23'd0} : {r_sign, r_exp + 8'd1, r_sum[23:1]};
          r_ovf       <= r_exp >= 8'd254;
          r_unf       <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end else if (r_sum == 25'd0) begin
          r_result    <= {r_sign & r_sign_s, 31'd0};
          r_ovf       <= 1'b0;
          r_unf       <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end else if (r_sum[23]) begin
          r_result    <= {r_sign, r_exp, r_sum[22:0]};
          r_ovf       <= 1'b0;
          r_unf       <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end else if (r_exp == 8'd1) begin
          r_result    <= {r_sign, 31'd0};
          r_ovf       <= 1'b0;
          r_unf       <= 1'b1;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end else begin
          r_sum <= r_sum << 1;
          r_exp <= r_exp - 8'd1;
        end
`ifdef FP_ADDSUB_SPECIALS_EN
        SPECIAL: begin
          r_result    <= r_spec;
          r_ovf       <= 1'b0;
          r_unf       <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
`endif
        DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign in_ready  = r_state == IDLE;
  assign busy      = r_state != IDLE;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign ovf       = r_ovf;
  assign unf       = r_unf;
endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb_fp_addsub_seq: vector table, handshake/reset sequences and random ops against a reference model
module tb_fp_addsub_seq;
  localparam int ITER = 0;
  logic        clk = 0, rst = 1, in_valid = 0, op = 0, out_ready = 1;
  logic        in_ready, out_valid, ovf, unf, busy;
  logic [31:0] a = 0, b = 0, result;
  int          checks = 0, errors = 0;

  fp_addsub_seq #(.ALIGN_ITER(ITER)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .ovf(ovf), .unf(unf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] a, b; logic op; logic [31:0] res; logic ovf, unf; int lat;} vec_t;
  typedef struct {logic [31:0] res; logic ovf, unf; int lat;} ref_t;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic longint mant(logic [31:0] x);
    return x[30:23] == 8'd0 ? 0 : longint'({1'b1, x[22:0]});
  endfunction

  // value-level model: pick the larger magnitude, align, add, then count leading zeros
  function automatic ref_t model(logic [31:0] x, logic [31:0] y, logic o);
    ref_t r;
    int ex, ey, e, d, lz, ac, nc;
    longint mb, ms, s;
    logic sx, sy, sb, ss;
`ifdef FP_ADDSUB_SPECIALS_EN
    logic nan;
`endif
    sx = x[31]; sy = y[31] ^ o;
    ex = int'(x[30:23]); ey = int'(y[30:23]);
    r.ovf = 0; r.unf = 0;
`ifdef FP_ADDSUB_SPECIALS_EN
    if (ex == 255 || ey == 255) begin
      nan = (ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0);
      r.res = (nan || (ex == 255 && ey == 255 && sx != sy)) ? 32'h7FC00000 : {ex == 255 ? sx : sy, 8'hFF, 23'd0};
      r.lat = 2;
      return r;
    end
`endif
    if (x[30:0] >= y[30:0]) begin
      e = ex; sb = sx; ss = sy; mb = mant(x); ms = mant(y); d = ex - ey;
    end else begin
      e = ey; sb = sy; ss = sx; mb = mant(y); ms = mant(x); d = ey - ex;
    end
    ms = d >= 24 ? 0 : ms >> d;
    s  = sb == ss ? mb + ms : mb - ms;
    ac = ITER == 0 ? 1 : (d == 0 ? 1 : (d > 24 ? 24 : d));
    if (s >= (longint'(1) << 24)) begin
      nc = 1;
      if (e + 1 >= 255) begin r.res = {sb, 8'hFF, 23'd0}; r.ovf = 1; end
      else r.res = {sb, 8'(e + 1), 23'(s >> 1)};
    end else if (s == 0) begin
      nc = 1;
      r.res = {sb & ss, 31'd0};
    end else begin
      lz = 0;
      while (s < (longint'(1) << 23)) begin s = s * 2; lz++; end
      if (lz > 0 && lz >= e) begin r.res = {sb, 31'd0}; r.unf = 1; nc = e; end
      else begin r.res = {sb, 8'(e - lz), 23'(s)}; nc = lz + 1; end
    end
    r.lat = 2 + nc + ac;
    return r;
  endfunction

  task automatic do_op(string nm, logic [31:0] ta, logic [31:0] tb_, logic to, ref_t e);
    int n;
    a = ta; b = tb_; op = to; in_valid = 1;
    chk({nm, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 0; a = $urandom; b = $urandom; op = 1'($urandom_range(0, 1));
    n = 1;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    chk({nm, ".latency"}, 32'(n), 32'(e.lat));
    chk({nm, ".result"}, result, e.res);
    chk({nm, ".ovf"}, 32'(ovf), 32'(e.ovf));
    chk({nm, ".unf"}, 32'(unf), 32'(e.unf));
    @(posedge clk); #1;
    chk({nm, ".out_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  vec_t tbl[10];

  initial begin
    int n, seen, ex, ey;
    logic [31:0] x, y;
    logic o;
    tbl[0] = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 4};
    tbl[1] = '{32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, 1'b0, 1'b0, 5};
    tbl[2] = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0, 4};
    tbl[3] = '{32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, ITER ? 27 : 4};
    tbl[4] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0, 4};
    tbl[5] = '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 1'b0, 1'b1, 4};
    tbl[6] = '{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 1'b0, 1'b0, 5};
    tbl[7] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0, 4};
    tbl[8] = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, ITER ? 27 : 4};
    tbl[9] = '{32'h3F800000, 32'h34000000, 1'b0, 32'h3F800001, 1'b0, 1'b0, ITER ? 26 : 4};

    repeat (3) @(posedge clk);
    #1;
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.result", result, 32'd0);
    chk("reset.ovf", 32'(ovf), 32'd0);
    chk("reset.unf", 32'(unf), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    rst = 0;

    for (int i = 0; i < 10; i++)
      do_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].op,
            '{res: tbl[i].res, ovf: tbl[i].ovf, unf: tbl[i].unf, lat: tbl[i].lat});

    out_ready = 0;
    a = 32'h3F800000; b = 32'h3F800000; op = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    n = 1;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    chk("stall.latency", 32'(n), 32'd4);
    a = 32'h40400000; b = 32'h3F800000; op = 1; in_valid = 1;
    repeat (3) begin
      chk("stall.result", result, 32'h40000000);
      chk("stall.in_ready", 32'(in_ready), 32'd0);
      chk("stall.out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    chk("stall.result_end", result, 32'h40000000);
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    chk("stall.release_valid", 32'(out_valid), 32'd0);
    chk("stall.release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("stall.no_capture", 32'(busy), 32'd0);

    a = 32'h3FC00000; b = 32'h3F800000; op = 1; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst.busy_norm", 32'(busy), 32'd1);
    rst = 1;
    @(posedge clk); #1;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.result", result, 32'd0);
    rst = 0;
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (out_valid) seen++; end
    chk("rst.no_output", 32'(seen), 32'd0);

`ifdef FP_ADDSUB_SPECIALS_EN
    do_op("inf_minus_inf", 32'h7F800000, 32'hFF800000, 1'b0, '{res: 32'h7FC00000, ovf: 0, unf: 0, lat: 2});
    do_op("inf_plus_one", 32'h7F800000, 32'h3F800000, 1'b0, '{res: 32'h7F800000, ovf: 0, unf: 0, lat: 2});
`endif

    for (int i = 0; i < 60; i++) begin
      ex = $urandom_range(0, 255);
      ey = $urandom_range(0, 1) ? $urandom_range(0, 255) : ex + $urandom_range(0, 6) - 3;
      ey = ey < 0 ? 0 : (ey > 255 ? 255 : ey);
      x = {1'($urandom), 8'(ex), 23'($urandom)};
      y = {1'($urandom), 8'(ey), 23'($urandom)};
      if ($urandom_range(0, 3) == 0) y[22:0] = x[22:0] ^ 23'($urandom_range(0, 15));
      o = 1'($urandom_range(0, 1));
      do_op($sformatf("rnd%0d_%h_%h_%0d", i, x, y, o), x, y, o, model(x, y, o));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_addsub_seq.md
# fp_addsub_seq

Multi-cycle IEEE-754 single-precision add/subtract sequencer. It accepts an operand pair through a valid/ready handshake, then sequences exponent compare/align, mantissa add/subtract, iterative normalization and pack through a small FSM. It presents one result per operation through an output valid/ready handshake. It sits between the operand issue logic and the result writeback of the floating-point unit.

## Interface
- ALIGN_ITER, default 0: 0 = barrel-shift alignment in one ALIGN cycle; 1 = shift the smaller mantissa right one bit per ALIGN cycle.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  high only in IDLE.
- a  input  32  operand A (sign, exp[7:0], frac[22:0]).
- b  input  32  operand B.
- op  input  1  0 = A+B, 1 = A−B.
- out_valid  output  1  result valid; held until out_ready.
- out_ready  input  1  consumer accepts result.
- result  output  32  packed result.
- ovf  output  1  overflow to ±inf on this result.
- unf  output  1  underflow flushed to zero on this result.
- busy  output  1  high in every state except IDLE.

## Operation
- States: IDLE, ALIGN, ADD, NORM, DONE (and SPECIAL when the macro is enabled).
- Transitions:
  - IDLE: on in_valid, capture a, b and op; go to ALIGN.
  - ALIGN: go to ADD.
  - ADD: go to NORM.
  - NORM: go to DONE when normalized.
  - DONE: on out_ready, go to IDLE.
- Unpack:
  - exp==0 means the operand is zero; denormals are flushed to zero.
  - Otherwise mantissa = {1, frac}, 24 bits.
  - Effective sign of B = b[31]^op.
- Compare: "big" is the larger exponent. On equal exponents, the larger frac is big; on a full tie, A is big. "small" is the other operand.
- Align:
  - small mantissa >> (exp_big − exp_small).
  - A difference ≥ 24 yields 0.
  - Bits shifted out are discarded (truncation, no guard/sticky).
  - ALIGN_ITER=1: ALIGN lasts max(1, min(diff, 24)) cycles.
- Add: 25-bit sum.
  - Equal effective signs: sum = big + small.
  - Otherwise: sum = big − small, which is never negative.
  - Sign = sign of big.
- NORM, evaluated each cycle:
  - sum[24]=1: shift right 1, exp+1, go to DONE. If the new exp reaches 255: result = ±inf (exp 255, frac 0), ovf=1.
  - sum==0: result = +0, except both effective signs negative gives −0. Go to DONE.
  - sum[23]=1: go to DONE.
  - Else: shift left 1, exp−1, stay in NORM. If exp reaches 0: result = signed zero, unf=1, go to DONE.
- Pack: {sign, exp, sum[22:0]}. result, ovf and unf are registered on entry to DONE.

## Timing
- Reset values: out_valid 0, result 0, ovf 0, unf 0, busy 0, state IDLE, so in_ready=1.
- Input handshake completes in the cycle where in_valid && in_ready. Inputs are sampled only then and never again until IDLE.
- out_valid first rises 4 cycles after the accept cycle (ALIGN_ITER=0, no left shift). Add 1 cycle per left shift. With ALIGN_ITER=1, add (ALIGN cycles − 1).
- While out_valid && !out_ready: result and flags are stable, and in_ready=0.
- Handshake completes on out_valid && out_ready. The next cycle is IDLE with out_valid=0; there is no accept in the same cycle as output (throughput ≤ 1 per 5 cycles).
- rst mid-operation: the operation is abandoned, all outputs return to reset values the next cycle, and no result is emitted.

## Configuration
- FP_ADDSUB_SPECIALS_EN defined:
  - An operand with exp==255 is detected in IDLE at accept, and the FSM goes IDLE→SPECIAL→DONE; out_valid rises 2 cycles after accept.
  - Any NaN input, or inf−inf under effective signs, gives 0x7FC00000.
  - inf ± finite gives that inf.
  - inf ± same-sign inf gives that inf.
  - ovf=0, unf=0.
- Undefined: exp==255 is treated as an ordinary normalized exponent, and there is no SPECIAL state.

## Test plan
- 0x3F800000 + 0x3F800000, op=0, out_ready=1 → result 0x40000000, out_valid 4 cycles after accept, ovf=0.
- 0x3FC00000 − 0x3F800000 (op=1) → 0x3F000000 after 5 cycles (one left shift). Also 0x3F800000 − 0x3F800000 → 0x00000000 after 4 cycles.
- 0x3F800000 + 0x30800000 (diff 30) → 0x3F800000. With ALIGN_ITER=1, out_valid appears 27 cycles after accept.
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, ovf=1. Also 0x00800000 − 0x00800001 → 0x80000000, unf=1.
- Hold out_ready=0 for 3 cycles after out_valid with in_valid=1 and new operands → result stable, in_ready=0, new operands not captured. Assert rst during NORM → out_valid never rises, busy=0 next cycle.
- With FP_ADDSUB_SPECIALS_EN: 0x7F800000 + 0xFF800000 → 0x7FC00000. 0x7F800000 + 0x3F800000 → 0x7F800000. Both with out_valid 2 cycles after accept.
